clkdiv_prog: RTL

- Runtime-programmable clock divider / tick generator on the 100 MHz system clock.
- Produces a near-50%-duty square wave `clk_out` and a one-cycle `tick` clock-enable pulse once per period.
- The divisor is reloadable at run time, with a glitch-free update at the period boundary.
- Feeds display multiplexers, debouncers and 1 Hz counters; downstream logic runs on `clk100MHz` gated by `tick`, never clocked by `clk_out`.

---
 rtl/clkdiv_prog_pkg.sv | 10 +
 rtl/clkdiv_prog_if.sv | 27 ++
 rtl/clkdiv_prog.sv | 100 ++++++++++
 3 files changed

// File: rtl/clkdiv_prog_pkg.sv
// Shared constants for the programmable clock divider: common divisors on the 100 MHz clock
// and the smallest divisor the divider accepts.
package clkdiv_prog_pkg;

    localparam int unsigned DIV_1HZ      = 100000000;
    localparam int unsigned DIV_1KHZ     = 100000;
    localparam int unsigned DIV_DEBOUNCE = 1000000;  // 10 ms
    localparam int unsigned MIN_DIV      = 2;

endpackage

// File: rtl/clkdiv_prog_if.sv
// Control/status bundle of the clock divider: divisor load and enables in, waveform and
// status flags out.
interface clkdiv_prog_if #(
    parameter int unsigned WIDTH = 27
);

    logic             en;
    logic             sync_clr;
    logic             div_load;
    logic [WIDTH-1:0] div_val;
    logic             clk_out;
    logic             tick;
    logic             pending;
    logic             load_err;
    logic [WIDTH-1:0] count;

    modport master (
        output en, sync_clr, div_load, div_val,
        input  clk_out, tick, pending, load_err, count
    );

    modport slave (
        input  en, sync_clr, div_load, div_val,
        output clk_out, tick, pending, load_err, count
    );

endinterface

// File: rtl/clkdiv_prog.sv
// Runtime-programmable divider on clk100MHz: square wave plus one-cycle tick per period, with
// the divisor swapped in only at a period boundary or on a synchronous restart.
module clkdiv_prog
    import clkdiv_prog_pkg::*;
#(
    parameter int unsigned WIDTH       = 27,
    parameter int unsigned DEFAULT_DIV = 100000000
) (
    input logic           clk100MHz,
    input logic           rst,
    clkdiv_prog_if.slave  bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             tc;
    logic             commit;
    logic [WIDTH-1:0] next_div;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high_len;

    assign load_ok  = bus.div_load && (bus.div_val >= WIDTH'(MIN_DIV));
    assign tc       = bus.en && (cnt_q == active_q - WIDTH'(1));
    assign cnt_inc  = cnt_q + WIDTH'(1);
    assign high_len = active_q - (active_q >> 1);
    // A load in the same cycle as a boundary bypasses the shadow register.
    assign commit   = load_ok || pending_q;
    assign next_div = load_ok ? bus.div_val : shadow_q;

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        err_d     = bus.div_load && !load_ok;

        if (load_ok) begin
            shadow_d  = bus.div_val;
            pending_d = 1'b1;
        end

        if (bus.sync_clr) begin
            cnt_d = '0;
            clk_d = 1'b1;
            if (commit) begin
                active_d  = next_div;
                pending_d = 1'b0;
            end
        end else if (!bus.en) begin
            // Frozen: counter and waveform hold, only the shadow can be updated.
        end else if (tc) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = 1'b1;
            if (commit) begin
                active_d  = next_div;
                pending_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_inc;
            clk_d = (cnt_inc < high_len);
        end
    end

    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            active_q  <= WIDTH'(DEFAULT_DIV);
            shadow_q  <= WIDTH'(DEFAULT_DIV);
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            clk_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            clk_q     <= clk_d;
            err_q     <= err_d;
        end
    end

    assign bus.count    = cnt_q;
    assign bus.clk_out  = clk_q;
    assign bus.tick     = tick_q;
    assign bus.pending  = pending_q;
    assign bus.load_err = err_q;

endmodule
